i_decode: RTL

- RV32I decode stage that sits directly downstream of i_fetch.
- Accepts raw 32-bit instructions over the IF→ID vacant/valid handshake.
- Tracks the PC of each accepted instruction and decodes it into register indices, a sign-extended immediate, a function code and an op class.
- Holds the result in a one-entry output register that the execute/issue stage drains via valid/ready.
- A writeback redirect flushes the held instruction and reloads the PC.

---
 rtl/i_decode_if.sv | 31 +++
 rtl/i_decode.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/i_decode_if.sv
// Bundle of the IF->ID vacant/valid handshake, the writeback redirect and the
// ID->EX valid/ready output; master drives the stage inputs, slave is the decoder.
interface i_decode_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  inst_valid;
  logic [INST_WIDTH-1:0] inst;
  logic                  inst_vacant;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  ex_ready;
  logic                  ex_valid;
  logic [ADDR_WIDTH-1:0] ex_pc;
  logic [3:0]            ex_op;
  logic [3:0]            ex_funct;
  logic [4:0]            ex_rd;
  logic [4:0]            ex_rs1;
  logic [4:0]            ex_rs2;
  logic [31:0]           ex_imm;

  modport master (
    output inst_valid, inst, redirect_valid, redirect_pc, ex_ready,
    input  inst_vacant, ex_valid, ex_pc, ex_op, ex_funct, ex_rd, ex_rs1, ex_rs2, ex_imm
  );

  modport slave (
    input  inst_valid, inst, redirect_valid, redirect_pc, ex_ready,
    output inst_vacant, ex_valid, ex_pc, ex_op, ex_funct, ex_rd, ex_rs1, ex_rs2, ex_imm
  );
endinterface

// File: rtl/i_decode.sv
// RV32I decode stage: tracks the PC of each accepted word, decodes it and holds
// the result in a one-entry output register drained by execute via valid/ready.
module i_decode #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic      clk_in,
  input logic      rst_in,
  i_decode_if.slave bus
);

  typedef enum logic [3:0] {
    OP_LUI     = 4'd0,
    OP_AUIPC   = 4'd1,
    OP_JAL     = 4'd2,
    OP_JALR    = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_LOAD    = 4'd5,
    OP_STORE   = 4'd6,
    OP_IMM     = 4'd7,
    OP_REG     = 4'd8,
    OP_FENCE   = 4'd9,
    OP_SYSTEM  = 4'd10,
    OP_ILLEGAL = 4'd15
  } op_e;

  function automatic logic [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] w);
    return {w[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  logic [31:0]           inst_s;
  logic [2:0]            funct3_s;
  logic [6:0]            funct7_s;
  logic                  legal_s;
  logic                  alt_s;
  op_e                   dec_op_s;
  logic [4:0]            dec_rd_s;
  logic [4:0]            dec_rs1_s;
  logic [4:0]            dec_rs2_s;
  logic [31:0]           dec_imm_s;
  logic                  inst_vacant_s;
  logic                  accept_s;

  logic                  ex_valid_r;
  logic [ADDR_WIDTH-1:0] ex_pc_r;
  op_e                   ex_op_r;
  logic [3:0]            ex_funct_r;
  logic [4:0]            ex_rd_r;
  logic [4:0]            ex_rs1_r;
  logic [4:0]            ex_rs2_r;
  logic [31:0]           ex_imm_r;
  logic [ADDR_WIDTH-1:0] pc_next_r;

  assign inst_s   = bus.inst[31:0];
  assign funct3_s = inst_s[14:12];
  assign funct7_s = inst_s[31:25];

  assign inst_vacant_s = !ex_valid_r || bus.ex_ready;
  assign accept_s      = bus.inst_valid && inst_vacant_s && !bus.redirect_valid;

  // Opcode decode; an illegal opcode or field combination leaves legal_s low.
  always_comb begin
    legal_s   = 1'b0;
    alt_s     = 1'b0;
    dec_op_s  = OP_ILLEGAL;
    dec_rd_s  = 5'd0;
    dec_rs1_s = 5'd0;
    dec_rs2_s = 5'd0;
    dec_imm_s = 32'd0;
    case (inst_s[6:0])
      7'b0110111: begin dec_op_s = OP_LUI;   legal_s = 1'b1; dec_rd_s = inst_s[11:7]; dec_imm_s = imm_u(inst_s); end
      7'b0010111: begin dec_op_s = OP_AUIPC; legal_s = 1'b1; dec_rd_s = inst_s[11:7]; dec_imm_s = imm_u(inst_s); end
      7'b1101111: begin dec_op_s = OP_JAL;   legal_s = 1'b1; dec_rd_s = inst_s[11:7]; dec_imm_s = imm_j(inst_s); end
      7'b1100111: begin
        dec_op_s = OP_JALR;  legal_s = (funct3_s == 3'b000);
        dec_rd_s = inst_s[11:7]; dec_rs1_s = inst_s[19:15]; dec_imm_s = imm_i(inst_s);
      end
      7'b1100011: begin
        dec_op_s  = OP_BRANCH; legal_s = (funct3_s != 3'b010) && (funct3_s != 3'b011);
        dec_rs1_s = inst_s[19:15]; dec_rs2_s = inst_s[24:20]; dec_imm_s = imm_b(inst_s);
      end
      7'b0000011: begin
        dec_op_s = OP_LOAD; legal_s = funct3_s inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        dec_rd_s = inst_s[11:7]; dec_rs1_s = inst_s[19:15]; dec_imm_s = imm_i(inst_s);
      end
      7'b0100011: begin
        dec_op_s  = OP_STORE; legal_s = funct3_s inside {3'b000, 3'b001, 3'b010};
        dec_rs1_s = inst_s[19:15]; dec_rs2_s = inst_s[24:20]; dec_imm_s = imm_s(inst_s);
      end
      7'b0010011: begin
        // Shift-immediates reuse the funct7 field; only SRAI may set bit 30.
        dec_op_s = OP_IMM;
        legal_s  = (funct3_s == 3'b001) ? (funct7_s == 7'b0000000) :
                   (funct3_s == 3'b101) ? ((funct7_s == 7'b0000000) || (funct7_s == 7'b0100000)) : 1'b1;
        alt_s    = (funct3_s == 3'b101) && inst_s[30];
        dec_rd_s = inst_s[11:7]; dec_rs1_s = inst_s[19:15]; dec_imm_s = imm_i(inst_s);
      end
      7'b0110011: begin
        dec_op_s  = OP_REG;
        legal_s   = (funct7_s == 7'b0000000) ||
                    ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
        alt_s     = inst_s[30];
        dec_rd_s  = inst_s[11:7]; dec_rs1_s = inst_s[19:15]; dec_rs2_s = inst_s[24:20];
      end
      7'b0001111: begin dec_op_s = OP_FENCE; legal_s = 1'b1; dec_rs1_s = inst_s[19:15]; dec_imm_s = imm_i(inst_s); end
      7'b1110011: begin
        dec_op_s = OP_SYSTEM; legal_s = 1'b1;
        dec_rd_s = inst_s[11:7]; dec_rs1_s = inst_s[19:15]; dec_imm_s = imm_i(inst_s);
      end
      default: legal_s = 1'b0;
    endcase
  end

  // Output register and PC tracker; reset beats redirect, redirect beats accept.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ex_valid_r <= 1'b0;
      ex_pc_r    <= '0;
      ex_op_r    <= OP_LUI;
      ex_funct_r <= 4'd0;
      ex_rd_r    <= 5'd0;
      ex_rs1_r   <= 5'd0;
      ex_rs2_r   <= 5'd0;
      ex_imm_r   <= 32'd0;
      pc_next_r  <= RESET_PC;
    end else if (bus.redirect_valid) begin
      ex_valid_r <= 1'b0;
      pc_next_r  <= bus.redirect_pc;
    end else if (accept_s) begin
      ex_valid_r <= 1'b1;
      ex_pc_r    <= pc_next_r;
      ex_op_r    <= legal_s ? dec_op_s : OP_ILLEGAL;
      ex_funct_r <= {legal_s && alt_s, funct3_s};
      ex_rd_r    <= legal_s ? dec_rd_s : 5'd0;
      ex_rs1_r   <= legal_s ? dec_rs1_s : 5'd0;
      ex_rs2_r   <= legal_s ? dec_rs2_s : 5'd0;
      ex_imm_r   <= legal_s ? dec_imm_s : 32'd0;
      pc_next_r  <= pc_next_r + ADDR_WIDTH'(32'd4);
    end else if (ex_valid_r && bus.ex_ready) begin
      ex_valid_r <= 1'b0;
    end
  end

  assign bus.inst_vacant = inst_vacant_s;
  assign bus.ex_valid    = ex_valid_r;
  assign bus.ex_pc       = ex_pc_r;
  assign bus.ex_op       = ex_op_r;
  assign bus.ex_funct    = ex_funct_r;
  assign bus.ex_rd       = ex_rd_r;
  assign bus.ex_rs1      = ex_rs1_r;
  assign bus.ex_rs2      = ex_rs2_r;
  assign bus.ex_imm      = ex_imm_r;

endmodule
